niosii_pio_bidir: RTL and testbench

//  Parametrised Avalon-MM PIO: WIDTH bidirectional bits, per-bit direction, atomic set/clear.

---
 rtl/niosii_pio_bidir.sv | 168 ++++++++++++++++
 tb/tb_niosii_pio_bidir.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/niosii_pio_bidir.sv
// niosii_pio_bidir
//   Avalon-MM parallel I/O slave for the Nios II system bus. WIDTH pins, each
//   with its own direction bit and an atomic set/clear path for the output
//   register. Pin inputs go through a SYNC_STAGES-deep synchroniser. A sticky
//   per-bit edge-capture register is then fed from the synchronised inputs.
//   It raises a maskable, registered interrupt.
//
// Ports
//   clk         in   1      system clock (single domain)
//   reset       in   1      synchronous, active-high reset
//   address     in   3      register word address
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe
//   read_n      in   1      active-low read strobe
//   writedata   in   32     write data, bits [WIDTH-1:0] used
//   readdata    out  32     registered read data, upper bits zero
//   in_port     in   WIDTH  asynchronous pin inputs
//   out_port    out  WIDTH  output data register
//   oe          out  WIDTH  per-bit output enable (direction register)
//   irq         out  1      registered interrupt request
//
// Register map (word addresses)
//   0 DATA     R: dir ? data_out : in_sync   W: data_out <= wd
//   1 DIR      R/W, 1 = output
//   2 IRQMASK  R/W
//   3 EDGECAP  R: edge_cap                   W: write-1-to-clear
//   4 OUTSET   W: data_out |= wd             R: 0
//   5 OUTCLR   W: data_out &= ~wd            R: 0
//   6,7        R: 0, writes ignored
module niosii_pio_bidir #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] OUT_RESET   = 32'h0,
  parameter logic [31:0] DIR_RESET   = 32'h0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          IRQ_TYPE    = 1,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_DIR  = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  // Edge detection is armed once in_prev holds a sample taken after reset.
  localparam logic [2:0] FILL_MAX = 3'(SYNC_STAGES + 1);

  logic             w_wr;
  logic             w_rd;
  logic [WIDTH-1:0] w_wd;
  logic             w_unused_wd;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_in_prev;
  logic [2:0]       r_fill;
  logic [WIDTH-1:0] w_in_sync;
  logic             w_armed;

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic [WIDTH-1:0] w_edge_raw;
  logic [WIDTH-1:0] w_edges;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_word;
  logic             w_irq_cond;

  assign w_wr        = chipselect & ~write_n;
  assign w_rd        = chipselect & ~read_n;
  assign w_wd        = writedata[WIDTH-1:0];
  // Upper writedata bits are architecturally ignored.
  assign w_unused_wd = ^writedata;

  assign w_in_sync   = r_sync[SYNC_STAGES-1];
  assign w_armed     = (r_fill == FILL_MAX);

  // Input synchroniser, delayed copy for edge detect, post-reset fill counter
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_in_prev <= '0;
      r_fill    <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_in_prev <= w_in_sync;
      if (!w_armed) r_fill <= r_fill + 3'd1;
    end
  end

  always_comb begin
    w_edge_raw = '0;
    case (EDGE_TYPE)
      0:       w_edge_raw =  w_in_sync & ~r_in_prev;
      1:       w_edge_raw = ~w_in_sync &  r_in_prev;
      default: w_edge_raw =  w_in_sync ^  r_in_prev;
    endcase
  end

  // Until the chain holds real pin samples, a difference against the zeroed
  // reset state is not a pin edge and must not be captured.
  assign w_edges = w_armed ? w_edge_raw : '0;
  assign w_clr   = (w_wr && address == ADDR_EDGE) ? w_wd : '0;

  always_comb begin
    w_rd_word = '0;
    case (address)
      ADDR_DATA: w_rd_word[WIDTH-1:0] = (r_dir & r_data_out) | (~r_dir & w_in_sync);
      ADDR_DIR:  w_rd_word[WIDTH-1:0] = r_dir;
      ADDR_MASK: w_rd_word[WIDTH-1:0] = r_mask;
      ADDR_EDGE: w_rd_word[WIDTH-1:0] = r_edge_cap;
      default:   w_rd_word = '0;
    endcase
  end

  assign w_irq_cond = (IRQ_TYPE == 0) ? |(w_in_sync & r_mask) : |(r_edge_cap & r_mask);

  // Register file, edge capture, read data and interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_out <= OUT_RESET[WIDTH-1:0];
      r_dir      <= DIR_RESET[WIDTH-1:0];
      r_mask     <= '0;
      r_edge_cap <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr) begin
        case (address)
          ADDR_DATA: r_data_out <= w_wd;
          ADDR_DIR:  r_dir      <= w_wd;
          ADDR_MASK: r_mask     <= w_wd;
          ADDR_SET:  r_data_out <= r_data_out | w_wd;
          ADDR_CLR:  r_data_out <= r_data_out & ~w_wd;
          default:   ;
        endcase
      end
      // A new edge outranks a same-cycle write-1-to-clear.
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_edges;
      if (w_rd) r_readdata <= w_rd_word;
      r_irq <= w_irq_cond;
    end
  end

  assign out_port = r_data_out;
  assign oe       = r_dir;
  assign readdata = r_readdata;
  assign irq      = r_irq;

endmodule

// File: tb/tb_niosii_pio_bidir.sv
module tb_niosii_pio_bidir;

  localparam logic [7:0] OUT_RST = 8'hA5;
  localparam logic [7:0] DIR_RST = 8'h0F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic        read_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [7:0]  in_port = 8'h00;
  logic [7:0]  out_port;
  logic [7:0]  oe;
  logic        irq;

  int total = 0;
  int bad   = 0;

  niosii_pio_bidir #(
    .WIDTH(8), .OUT_RESET(32'hA5), .DIR_RESET(32'h0F),
    .EDGE_TYPE(0), .IRQ_TYPE(1), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata),
    .readdata(readdata), .in_port(in_port), .out_port(out_port),
    .oe(oe), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: register values plus a history of pin samples taken
  // since reset. A pin value sampled at edge j is readable at edge j+2 and
  // is compared with the one sampled at edge j-1 for rising edges; only
  // pairs of samples both taken after reset count.
  logic [7:0]  m_out  = OUT_RST;
  logic [7:0]  m_dir  = DIR_RST;
  logic [7:0]  m_mask = 8'h00;
  logic [7:0]  m_cap  = 8'h00;
  logic [31:0] m_rd   = 32'h0;
  logic        m_irq  = 1'b0;
  logic [7:0]  hist[$];

  always @(posedge clk) begin
    logic       w, r;
    logic [7:0] wd, s, edges, rv;
    if (reset) begin
      m_out = OUT_RST; m_dir = DIR_RST; m_mask = 8'h00; m_cap = 8'h00;
      m_rd = 32'h0; m_irq = 1'b0;
      hist.delete();
    end else begin
      w  = chipselect && !write_n;
      r  = chipselect && !read_n;
      wd = writedata[7:0];
      hist.push_back(in_port);
      s = (hist.size() >= 3) ? hist[hist.size()-3] : 8'h00;
      edges = 8'h00;
      if (hist.size() >= 4) edges = s & ~hist[hist.size()-4];
      m_irq = |(m_cap & m_mask);
      if (r) begin
        rv = 8'h00;
        if (address == 3'd0) rv = (m_dir & m_out) | (~m_dir & s);
        if (address == 3'd1) rv = m_dir;
        if (address == 3'd2) rv = m_mask;
        if (address == 3'd3) rv = m_cap;
        m_rd = {24'h0, rv};
      end
      m_cap = (m_cap & ~((w && address == 3'd3) ? wd : 8'h00)) | edges;
      if (w) begin
        if (address == 3'd0) m_out = wd;
        if (address == 3'd1) m_dir = wd;
        if (address == 3'd2) m_mask = wd;
        if (address == 3'd4) m_out = m_out | wd;
        if (address == 3'd5) m_out = m_out & ~wd;
      end
      if (hist.size() > 4) void'(hist.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [2:0] a, input logic w, input logic r, input logic [31:0] d);
    address = a; chipselect = w | r; write_n = ~w; read_n = ~r; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++; if (out_port !== 8'hA5) begin bad++; $display("FAIL reset_out: got %h want a5", out_port); end
    total++; if (oe !== 8'h0F) begin bad++; $display("FAIL reset_oe: got %h want 0f", oe); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL reset_rd: got %h want 0", readdata); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_set_clr();
    bus(3'd0, 1'b1, 1'b0, 32'h1234_563C);
    total++; if (out_port !== 8'h3C) begin bad++; $display("FAIL data_wr: got %h want 3c", out_port); end
    bus(3'd4, 1'b1, 1'b0, 32'h81);
    total++; if (out_port !== 8'hBD) begin bad++; $display("FAIL outset: got %h want bd", out_port); end
    bus(3'd5, 1'b1, 1'b0, 32'h0C);
    total++; if (out_port !== 8'hB1) begin bad++; $display("FAIL outclr: got %h want b1", out_port); end
    bus(3'd1, 1'b1, 1'b0, 32'hFF);
    total++; if (oe !== 8'hFF) begin bad++; $display("FAIL dir_wr: got %h want ff", oe); end
    bus(3'd0, 1'b0, 1'b1, 32'h0);
    total++; if (readdata !== 32'hB1) begin bad++; $display("FAIL data_rd: got %h want b1", readdata); end
  endtask

  task automatic test_mixed_read();
    bus(3'd1, 1'b1, 1'b0, 32'hF0);
    bus(3'd0, 1'b1, 1'b0, 32'hA0);
    in_port = 8'h05;
    repeat (4) tick();
    bus(3'd0, 1'b0, 1'b1, 32'h0);
    total++; if (readdata !== 32'hA5) begin bad++; $display("FAIL mixed_rd: got %h want a5", readdata); end
    tick(); tick();
    total++; if (readdata !== 32'hA5) begin bad++; $display("FAIL rd_hold: got %h want a5", readdata); end
  endtask

  task automatic test_edge_irq();
    in_port = 8'h00;
    repeat (4) tick();
    bus(3'd3, 1'b1, 1'b0, 32'hFF);
    bus(3'd2, 1'b1, 1'b0, 32'h01);
    tick(); tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_idle: got %b want 0", irq); end
    in_port = 8'h01;
    tick(); tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early: got %b want 0", irq); end
    bus(3'd3, 1'b0, 1'b1, 32'h0);
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL cap_early: got %h want 0", readdata); end
    bus(3'd3, 1'b0, 1'b1, 32'h0);
    total++; if (readdata !== 32'h1) begin bad++; $display("FAIL cap_set: got %h want 1", readdata); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set: got %b want 1", irq); end
    bus(3'd3, 1'b1, 1'b0, 32'h01);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_lag: got %b want 1", irq); end
    tick();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clr: got %b want 0", irq); end
  endtask

  task automatic test_race();
    in_port = 8'h05;
    tick(); tick();
    bus(3'd3, 1'b1, 1'b0, 32'h04);
    bus(3'd3, 1'b0, 1'b1, 32'h0);
    total++; if (readdata !== 32'h4) begin bad++; $display("FAIL race_cap: got %h want 4", readdata); end
    bus(3'd3, 1'b1, 1'b0, 32'h04);
    bus(3'd3, 1'b0, 1'b1, 32'h0);
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL w1c: got %h want 0", readdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL race_irq: got %b want 0", irq); end
  endtask

  task automatic test_misc();
    bus(3'd1, 1'b1, 1'b0, 32'hF0);
    bus(3'd1, 1'b1, 1'b1, 32'hFFFF_FF5A);
    total++; if (readdata !== 32'hF0) begin bad++; $display("FAIL rdwr_old: got %h want f0", readdata); end
    total++; if (oe !== 8'h5A) begin bad++; $display("FAIL rdwr_oe: got %h want 5a", oe); end
    bus(3'd1, 1'b0, 1'b1, 32'h0);
    total++; if (readdata !== 32'h5A) begin bad++; $display("FAIL dir_rd: got %h want 5a", readdata); end
    bus(3'd6, 1'b1, 1'b0, 32'hFF);
    bus(3'd7, 1'b1, 1'b0, 32'hFF);
    total++; if (out_port !== 8'hA0 || oe !== 8'h5A) begin bad++; $display("FAIL ignored_wr: got %h/%h want a0/5a", out_port, oe); end
    for (int a = 4; a < 8; a++) begin
      bus(3'(a), 1'b0, 1'b1, 32'h0);
      total++; if (readdata !== 32'h0) begin bad++; $display("FAIL rd_zero_%0d: got %h want 0", a, readdata); end
      bus(3'd1, 1'b0, 1'b1, 32'h0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      int op;
      op = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      reset = ($urandom_range(0, 79) == 0);
      address = 3'($urandom_range(0, 7));
      chipselect = (op != 0);
      write_n = !(op == 1 || op == 3);
      read_n  = !(op == 2 || op == 3);
      writedata = $urandom;
      tick();
      chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; reset = 1'b0;
      total++; if (out_port !== m_out) begin bad++; $display("FAIL rnd_out@%0d: got %h want %h", i, out_port, m_out); end
      total++; if (oe !== m_dir) begin bad++; $display("FAIL rnd_oe@%0d: got %h want %h", i, oe, m_dir); end
      total++; if (irq !== m_irq) begin bad++; $display("FAIL rnd_irq@%0d: got %b want %b", i, irq, m_irq); end
      total++; if (readdata !== m_rd) begin bad++; $display("FAIL rnd_rd@%0d: got %h want %h", i, readdata, m_rd); end
    end
  endtask

  task automatic test_reset_mid_read();
    bus(3'd1, 1'b1, 1'b0, 32'h3C);
    bus(3'd1, 1'b0, 1'b1, 32'h0);
    total++; if (readdata !== 32'h3C) begin bad++; $display("FAIL pre_rst_rd: got %h want 3c", readdata); end
    bus(3'd2, 1'b1, 1'b0, 32'hFF);
    in_port = 8'h00; repeat (4) tick();
    in_port = 8'hFF; repeat (4) tick();
    address = 3'd0; chipselect = 1'b1; read_n = 1'b0; reset = 1'b1;
    tick();
    chipselect = 1'b0; read_n = 1'b1; reset = 1'b0;
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL rst_rd: got %h want 0", readdata); end
    total++; if (out_port !== 8'hA5 || oe !== 8'h0F) begin bad++; $display("FAIL rst_regs: got %h/%h want a5/0f", out_port, oe); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want 0", irq); end
    repeat (8) tick();
    bus(3'd3, 1'b0, 1'b1, 32'h0);
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL no_spurious: got %h want 0", readdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL post_rst_irq: got %b want 0", irq); end
  endtask

  initial begin
    test_reset();
    test_set_clr();
    test_mixed_read();
    test_edge_irq();
    test_race();
    test_misc();
    test_random();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
